// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: instruction fields,
// datapath select codes and the sequencer state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'd2;

  localparam logic [1:0] ALU_B_RT     = 2'd0;
  localparam logic [1:0] ALU_B_FOUR   = 2'd1;
  localparam logic [1:0] ALU_B_IMM    = 2'd2;
  localparam logic [1:0] ALU_B_BRANCH = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_LW_WB    = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BNE      = 4'd10,
    S_J        = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14
  } stateT;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct to ALU operation; also reports whether the funct is an ALU
// instruction this core executes.
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] aluOp,
  output logic       isAluFunct
);

  always_comb begin
    aluOp      = ALU_ADD;
    isAluFunct = 1'b1;
    case (funct)
      FN_ADD:  aluOp = ALU_ADD;
      FN_SUB:  aluOp = ALU_SUB;
      FN_SLT:  aluOp = ALU_SLT;
      default: isAluFunct = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps each instruction through its states,
// drives datapath enables/selects, counts retired instructions.
//
// state    | meaning
// FETCH    | read instr at PC, PC <= PC+4 on mem_ready (idle one cycle after reset)
// DECODE   | precompute branch target, dispatch on opcode/funct
// EXEC_R   | ALU rs op rt
// WB_R     | write ALUOut to rd
// EXEC_I   | ALU rs op imm (ADDI/XORI)
// WB_I     | write ALUOut to rt
// MEM_ADDR | ALUOut <= rs + sext(imm)
// MEM_RD   | load; MDR on mem_ready
// LW_WB    | write MDR to rt
// MEM_WR   | store; done on mem_ready
// BNE      | compare rs/rt, take branch when not equal
// J / JAL  | jump (JAL also links PC+4 into $31)
// JR       | PC <= rs
// HALT     | unsupported encoding seen; parked until reset
module multicycle_control
  import mips_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_we,
  output logic                mdr_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                zext_imm,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  stateT      state;
  stateT      nextState;
  logic       armed;
  logic       retireNow;
  logic [2:0] aluOpC;
  logic [2:0] rAluOp;
  logic       rFunctOk;
  logic [5:0] op;
  logic [5:0] fn;

  assign op     = 6'(opcode);
  assign fn     = 6'(funct);
  assign alu_op = ALU_OP_W'(aluOpC);

  alu_op_decode uAluOpDecode (
    .funct      (fn),
    .aluOp      (rAluOp),
    .isAluFunct (rFunctOk)
  );

  // armed holds FETCH quiet for the first cycle after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      armed   <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= nextState;
      armed <= 1'b1;
      if (nextState == S_HALT) illegal <= 1'b1;
      if (retireNow) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nextState  = state;
    retireNow  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_we     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = MEM_TO_REG_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = ALU_B_RT;
    aluOpC     = ALU_ADD;
    zext_imm   = 1'b0;

    case (state)
      S_FETCH: begin
        if (armed) begin
          mem_req   = 1'b1;
          alu_src_b = ALU_B_FOUR;
          aluOpC    = ALU_ADD;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            pc_src    = PC_SRC_ALU;
            nextState = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        alu_src_b = ALU_B_BRANCH;
        aluOpC    = ALU_ADD;
        case (op)
          OP_RTYPE: begin
            if (rFunctOk)        nextState = S_EXEC_R;
            else if (fn == FN_JR) nextState = S_JR;
            else                 nextState = S_HALT;
          end
          OP_ADDI, OP_XORI: nextState = S_EXEC_I;
          OP_LW, OP_SW:     nextState = S_MEM_ADDR;
          OP_BNE:           nextState = S_BNE;
          OP_J:             nextState = S_J;
          OP_JAL:           nextState = S_JAL;
          default:          nextState = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_RT;
        aluOpC    = rAluOp;
        nextState = S_WB_R;
      end
      S_WB_R: begin
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RD;
        mem_to_reg = MEM_TO_REG_ALUOUT;
        retireNow  = 1'b1;
        nextState  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        if (op == OP_XORI) begin
          aluOpC   = ALU_XOR;
          zext_imm = 1'b1;
        end else begin
          aluOpC = ALU_ADD;
        end
        nextState = S_WB_I;
      end
      S_WB_I: begin
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = MEM_TO_REG_ALUOUT;
        retireNow  = 1'b1;
        nextState  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        aluOpC    = ALU_ADD;
        nextState = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_we    = 1'b1;
          nextState = S_LW_WB;
        end
      end
      S_LW_WB: begin
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_to_reg = MEM_TO_REG_MDR;
        retireNow  = 1'b1;
        nextState  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retireNow = 1'b1;
          nextState = S_FETCH;
        end
      end
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_RT;
        aluOpC    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_we     = ~alu_zero;
        retireNow = 1'b1;
        nextState = S_FETCH;
      end
      S_J: begin
        pc_src    = PC_SRC_JUMP;
        pc_we     = 1'b1;
        retireNow = 1'b1;
        nextState = S_FETCH;
      end
      S_JAL: begin
        pc_src     = PC_SRC_JUMP;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = MEM_TO_REG_PC;
        retireNow  = 1'b1;
        nextState  = S_FETCH;
      end
      S_JR: begin
        pc_src    = PC_SRC_RS;
        pc_we     = 1'b1;
        retireNow = 1'b1;
        nextState = S_FETCH;
      end
      S_HALT: nextState = S_HALT;
      default: nextState = S_FETCH;
    endcase
  end

endmodule
